// File: rtl/enigma_pkg.sv
// Shared letter type, FSM state encoding and rotor constants for the Enigma stepping controller.
`timescale 1ns/1ps
package enigma_pkg;

    localparam int unsigned LETTER_W        = 5;
    localparam int unsigned ALPHA           = 26;
    localparam int unsigned NOTCH_R_DEFAULT = 21;
    localparam int unsigned NOTCH_M_DEFAULT = 4;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t LAST_LETTER = letter_t'(ALPHA - 1);

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StLoad,
        StStep,
        StEmit
    } state_e;

    // Out-of-range letter codes collapse to A rather than poisoning the rotors.
    function automatic letter_t clamp_letter(letter_t v);
        return (v > LAST_LETTER) ? '0 : v;
    endfunction

    function automatic letter_t next_letter(letter_t v);
        return (v >= LAST_LETTER) ? '0 : v + letter_t'(1);
    endfunction

endpackage

// File: rtl/enigma_pos_ctr.sv
// Mod-26 rotor position shadow counter with synchronous load; load has priority over increment.
`timescale 1ns/1ps
module enigma_pos_ctr
    import enigma_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  letter_t load_val,
    input  logic    inc,
    output letter_t pos
);

    letter_t pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (load) begin
            pos_d = load_val;
        end else if (inc) begin
            pos_d = next_letter(pos_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/enigma_step_ctrl.sv
// Enigma rotor stepping controller: accepts keypresses, steps rotors with the double-step
// anomaly, forwards the letter to the rotor chain and keeps shadow copies of rotor positions.
`timescale 1ns/1ps
module enigma_step_ctrl
    import enigma_pkg::*;
#(
    parameter int unsigned NOTCH_R = NOTCH_R_DEFAULT,
    parameter int unsigned NOTCH_M = NOTCH_M_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [LETTER_W-1:0]   start_r,
    input  logic [LETTER_W-1:0]   start_m,
    input  logic [LETTER_W-1:0]   start_l,
    input  logic                  key_valid,
    input  logic [LETTER_W-1:0]   key_in,
    output logic                  key_ready,
    output logic                  char_valid,
    output logic [LETTER_W-1:0]   char_out,
    input  logic                  char_ready,
    output logic [2:0]            rotor_en,
    output logic [2:0]            rotor_load,
    output logic [2:0]            rotor_inc,
    output logic                  ld_sel,
    output logic [3*LETTER_W-1:0] ld_val,
    output logic [LETTER_W-1:0]   pos_r,
    output logic [LETTER_W-1:0]   pos_m,
    output logic [LETTER_W-1:0]   pos_l,
    output logic                  key_err
);

    localparam letter_t NotchR = letter_t'(NOTCH_R);
    localparam letter_t NotchM = letter_t'(NOTCH_M);

    state_e  state_q, state_d;
    letter_t key_q, key_d;

    logic       key_take;
    logic       key_good;
    logic       notch_r_hit;
    logic       notch_m_hit;
    logic [2:0] step_mask;

    // A pending load request masks the keyboard so a load always wins the tie.
    assign key_take = (state_q == StIdle) && !load_req && key_valid;
    assign key_good = key_in <= LAST_LETTER;

    assign notch_r_hit = (pos_r == NotchR);
    assign notch_m_hit = (pos_m == NotchM);
    // Middle rotor steps on its own notch too: the historical double step.
    assign step_mask   = {notch_m_hit, notch_r_hit | notch_m_hit, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        unique case (state_q)
            StInit, StLoad: state_d = StIdle;
            StIdle: begin
                if (load_req) begin
                    state_d = StLoad;
                end else if (key_take && key_good) begin
                    key_d   = key_in;
                    state_d = StStep;
                end
            end
            StStep: state_d = StEmit;
            StEmit: begin
                if (char_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_comb begin
        rotor_en   = '0;
        rotor_load = '0;
        rotor_inc  = '0;
        ld_sel     = 1'b0;
        ld_val     = '0;
        key_ready  = 1'b0;
        key_err    = 1'b0;
        char_valid = 1'b0;
        char_out   = '0;
        unique case (state_q)
            StInit: begin
                rotor_en   = 3'b111;
                rotor_load = 3'b111;
                ld_sel     = 1'b1;
            end
            StLoad: begin
                rotor_en   = 3'b111;
                rotor_load = 3'b111;
                ld_sel     = 1'b1;
                ld_val     = {clamp_letter(start_l), clamp_letter(start_m), clamp_letter(start_r)};
            end
            StIdle: begin
                key_ready = !load_req;
                key_err   = key_take && !key_good;
            end
            StStep: begin
                rotor_en  = step_mask;
                rotor_inc = step_mask;
            end
            StEmit: begin
                char_valid = 1'b1;
                char_out   = key_q;
            end
            default: ;
        endcase
    end

    enigma_pos_ctr u_pos_r (
        .clk      (clk),
        .rst      (rst),
        .load     (rotor_load[0]),
        .load_val (ld_val[LETTER_W-1:0]),
        .inc      (rotor_inc[0]),
        .pos      (pos_r)
    );

    enigma_pos_ctr u_pos_m (
        .clk      (clk),
        .rst      (rst),
        .load     (rotor_load[1]),
        .load_val (ld_val[2*LETTER_W-1:LETTER_W]),
        .inc      (rotor_inc[1]),
        .pos      (pos_m)
    );

    enigma_pos_ctr u_pos_l (
        .clk      (clk),
        .rst      (rst),
        .load     (rotor_load[2]),
        .load_val (ld_val[3*LETTER_W-1:2*LETTER_W]),
        .inc      (rotor_inc[2]),
        .pos      (pos_l)
    );

    ap_ld_sel_full: assert property (@(posedge clk) disable iff (rst)
        ld_sel |-> (rotor_load == 3'b111));
    ap_char_out_idle: assert property (@(posedge clk) disable iff (rst)
        !char_valid |-> (char_out == '0));
    ap_pos_range: assert property (@(posedge clk) disable iff (rst)
        (pos_r <= LAST_LETTER) && (pos_m <= LAST_LETTER) && (pos_l <= LAST_LETTER));

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Self-checking bench for enigma_step_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural rotor model.
`timescale 1ns/1ps
module tb_enigma_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic [4:0]  start_r = '0, start_m = '0, start_l = '0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_in = '0;
    logic        key_ready;
    logic        char_valid;
    logic [4:0]  char_out;
    logic        char_ready = 1'b0;
    logic [2:0]  rotor_en, rotor_load, rotor_inc;
    logic        ld_sel;
    logic [14:0] ld_val;
    logic [4:0]  pos_r, pos_m, pos_l;
    logic        key_err;

    enigma_step_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load_req   (load_req),
        .start_r    (start_r),
        .start_m    (start_m),
        .start_l    (start_l),
        .key_valid  (key_valid),
        .key_in     (key_in),
        .key_ready  (key_ready),
        .char_valid (char_valid),
        .char_out   (char_out),
        .char_ready (char_ready),
        .rotor_en   (rotor_en),
        .rotor_load (rotor_load),
        .rotor_inc  (rotor_inc),
        .ld_sel     (ld_sel),
        .ld_val     (ld_val),
        .pos_r      (pos_r),
        .pos_m      (pos_m),
        .pos_l      (pos_l),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the machine is doing this cycle, plus rotor letters as integers.
    localparam int PInit = 0, PIdle = 1, PLoad = 2, PStep = 3, PEmit = 4;
    int ph = PInit;
    int mr = 0, mm = 0, ml = 0, mkey = 0;

    always @(negedge clk) begin
        int e_en, e_ld, e_inc, e_sel, e_val, e_kr, e_ke, e_cv, e_co;
        int sr, sm, sl, mid, lft;
        if (rst) begin
            ph = PInit; mr = 0; mm = 0; ml = 0;
        end
        e_en = 0; e_ld = 0; e_inc = 0; e_sel = 0; e_val = 0;
        e_kr = 0; e_ke = 0; e_cv = 0; e_co = 0;
        sr = (start_r > 25) ? 0 : int'(start_r);
        sm = (start_m > 25) ? 0 : int'(start_m);
        sl = (start_l > 25) ? 0 : int'(start_l);
        mid = (mr == 21 || mm == 4) ? 1 : 0;
        lft = (mm == 4) ? 1 : 0;
        case (ph)
            PInit: begin e_en = 7; e_ld = 7; e_sel = 1; end
            PLoad: begin e_en = 7; e_ld = 7; e_sel = 1; e_val = sl * 1024 + sm * 32 + sr; end
            PIdle: begin
                e_kr = load_req ? 0 : 1;
                e_ke = (!load_req && key_valid && key_in > 25) ? 1 : 0;
            end
            PStep: begin e_inc = 1 + 2 * mid + 4 * lft; e_en = e_inc; end
            PEmit: begin e_cv = 1; e_co = mkey; end
            default: ;
        endcase
        chk("rotor_en", int'(rotor_en), e_en);
        chk("rotor_load", int'(rotor_load), e_ld);
        chk("rotor_inc", int'(rotor_inc), e_inc);
        chk("ld_sel", int'(ld_sel), e_sel);
        chk("ld_val", int'(ld_val), e_val);
        chk("key_ready", int'(key_ready), e_kr);
        chk("key_err", int'(key_err), e_ke);
        chk("char_valid", int'(char_valid), e_cv);
        chk("char_out", int'(char_out), e_co);
        chk("pos_r", int'(pos_r), mr);
        chk("pos_m", int'(pos_m), mm);
        chk("pos_l", int'(pos_l), ml);
        if (!rst) begin
            case (ph)
                PInit: begin mr = 0; mm = 0; ml = 0; ph = PIdle; end
                PLoad: begin mr = sr; mm = sm; ml = sl; ph = PIdle; end
                PIdle: begin
                    if (load_req) ph = PLoad;
                    else if (key_valid && key_in <= 25) begin mkey = int'(key_in); ph = PStep; end
                end
                PStep: begin
                    mr = (mr + 1) % 26;
                    mm = (mm + mid) % 26;
                    ml = (ml + lft) % 26;
                    ph = PEmit;
                end
                PEmit: if (char_ready) ph = PIdle;
                default: ph = PInit;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ph != PIdle && n < 50) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", (ph == PIdle) ? 1 : 0, 1);
    endtask

    task automatic do_load(input int r, input int m, input int l);
        wait_idle();
        start_r = 5'(r); start_m = 5'(m); start_l = 5'(l);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
    endtask

    // Leaves the DUT in the step cycle for the caller to inspect.
    task automatic key_step(input int k);
        wait_idle();
        key_valid = 1'b1;
        key_in = 5'(k);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic finish_emit();
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("lit_init_load", int'(rotor_load), 7);
        chk("lit_init_ld_val", int'(ld_val), 0);
        chk("lit_init_key_ready", int'(key_ready), 0);
        tick();
        chk("lit_idle_key_ready", int'(key_ready), 1);
        chk("lit_idle_load_off", int'(rotor_load), 0);
        chk("lit_idle_pos", int'({pos_l, pos_m, pos_r}), 0);

        do_load(0, 0, 0);
        key_step(7);
        chk("lit_k7_inc", int'(rotor_inc), 1);
        tick();
        chk("lit_k7_inc_off", int'(rotor_inc), 0);
        chk("lit_k7_pos_r", int'(pos_r), 1);
        chk("lit_k7_valid", int'(char_valid), 1);
        repeat (3) tick();
        chk("lit_k7_char_held", int'(char_out), 7);
        finish_emit();
        chk("lit_k7_released", int'(char_valid), 0);

        do_load(21, 0, 0);
        key_step(3);
        chk("lit_notch_r_inc", int'(rotor_inc), 3);
        tick();
        chk("lit_notch_r_pos_r", int'(pos_r), 22);
        chk("lit_notch_r_pos_m", int'(pos_m), 1);
        finish_emit();

        do_load(20, 3, 0);
        key_step(0);
        chk("lit_ds1_inc", int'(rotor_inc), 1);
        tick();
        chk("lit_ds1_ADV", int'({pos_l, pos_m, pos_r}), 0 * 1024 + 3 * 32 + 21);
        finish_emit();
        key_step(1);
        chk("lit_ds2_inc", int'(rotor_inc), 3);
        tick();
        chk("lit_ds2_AEW", int'({pos_l, pos_m, pos_r}), 0 * 1024 + 4 * 32 + 22);
        finish_emit();
        key_step(2);
        chk("lit_ds3_inc", int'(rotor_inc), 7);
        tick();
        chk("lit_ds3_BFX", int'({pos_l, pos_m, pos_r}), 1 * 1024 + 5 * 32 + 23);
        finish_emit();

        wait_idle();
        start_r = 5'd0; start_m = 5'd0; start_l = 5'd0;
        load_req = 1'b1; key_valid = 1'b1; key_in = 5'd5;
        #1 chk("lit_tie_key_ready", int'(key_ready), 0);
        tick();
        chk("lit_tie_load_first", int'(rotor_load), 7);
        load_req = 1'b0;
        tick();
        chk("lit_tie_key_ready_again", int'(key_ready), 1);
        tick();
        key_valid = 1'b0;
        chk("lit_tie_step", int'(rotor_inc), 1);
        tick();
        chk("lit_tie_char", int'(char_out), 5);
        finish_emit();

        wait_idle();
        key_valid = 1'b1; key_in = 5'd27;
        #1 chk("lit_bad_key_err", int'(key_err), 1);
        chk("lit_bad_key_no_inc", int'(rotor_inc), 0);
        tick();
        chk("lit_bad_key_no_step", int'(rotor_inc), 0);
        chk("lit_bad_key_stays_idle", int'(key_ready), 1);
        key_valid = 1'b0;
        #1 chk("lit_bad_key_err_clear", int'(key_err), 0);

        key_step(9);
        tick();
        chk("lit_rst_emit_valid", int'(char_valid), 1);
        rst = 1'b1;
        #1 chk("lit_rst_emit_drop", int'(char_valid), 0);
        tick();
        rst = 1'b0;
        #1 chk("lit_rst_reinit_load", int'(rotor_load), 7);
        chk("lit_rst_reinit_val", int'(ld_val), 0);
        tick();
        chk("lit_rst_reinit_idle", int'(key_ready), 1);

        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 399) == 0);
            load_req   = ($urandom_range(0, 15) == 0);
            key_valid  = $urandom_range(0, 1) == 1;
            key_in     = 5'($urandom_range(0, 31));
            char_ready = $urandom_range(0, 2) != 0;
            start_r    = 5'($urandom_range(0, 31));
            start_m    = ($urandom_range(0, 3) == 0) ? 5'd4 : 5'($urandom_range(0, 31));
            start_l    = 5'($urandom_range(0, 31));
            tick();
        end
        rst = 1'b0; load_req = 1'b0; key_valid = 1'b0; char_ready = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/enigma_step_ctrl.md
ENIGMA_STEP_CTRL -- requirements
Module: enigma_step_ctrl

Interface
REQ-001 SHALL have parameter NOTCH_R, default 21, right-rotor turnover position (0=A).
REQ-002 SHALL have parameter NOTCH_M, default 4, middle-rotor turnover position.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: load_req  in  1  request to load start positions.
REQ-006 SHALL have ports: start_r/start_m/start_l  in  5 each  start positions for load.
REQ-007 SHALL have ports: key_valid  in  1, key_in  in  5, key_ready  out  1  keypress handshake.
REQ-008 SHALL have ports: char_valid  out  1, char_out  out  5, char_ready  in  1  handshake to rotor chain.
REQ-009 SHALL have ports: rotor_en, rotor_load, rotor_inc  out  3 each  per-rotor controls, bit0=right, bit1=middle, bit2=left.
REQ-010 SHALL have ports: ld_sel  out  1, ld_val  out  15  rotor-input mux select and load values, [4:0]=right.
REQ-011 SHALL have ports: pos_r/pos_m/pos_l  out  5 each  shadow rotor positions; key_err  out  1  bad-key pulse.

Function
REQ-012 SHALL implement states INIT, IDLE, LOAD, STEP, EMIT.
REQ-013 SHALL assert key_ready only in IDLE with load_req low.
REQ-014 SHALL, in IDLE with load_req=1, go to LOAD; load_req SHALL win over a simultaneous key_valid.
REQ-015 SHALL, in LOAD and INIT, drive rotor_en=rotor_load=3'b111, ld_sel=1 for exactly one cycle, copy ld_val into pos_*, then go to IDLE.
REQ-016 SHALL, in LOAD, set ld_val to start_*; any start value >25 SHALL be replaced by 0.
REQ-017 SHALL, in INIT, set ld_val to 0 for all three rotors.
REQ-018 SHALL, on key_valid&key_ready with key_in<=25, capture key_in and go to STEP.
REQ-019 SHALL, on key_valid&key_ready with key_in>25, pulse key_err for one cycle, stay in IDLE and not step.
REQ-020 SHALL, in STEP, for one cycle drive rotor_en=rotor_inc with right bit=1, middle bit=(pos_r==NOTCH_R)|(pos_m==NOTCH_M), and left bit=(pos_m==NOTCH_M), all from pre-step positions.
REQ-021 SHALL apply the same increments to pos_* modulo 26 (25->0), then go to EMIT.
REQ-022 SHALL, in EMIT, hold char_valid=1 and char_out=captured key until char_ready=1, then go to IDLE the next cycle.
REQ-023 SHALL keep rotor_en/load/inc, ld_sel and key_err at 0 outside the cases above, and char_out at 0 when char_valid=0.
REQ-024 SHALL give a keypress-to-char_valid latency of 2 cycles.

Reset
REQ-025 SHALL, on rst, go to INIT asynchronously and clear pos_* to 0, char_valid, key_ready and key_err to 0.
REQ-026 SHALL, on reset mid-operation, abandon any pending STEP or EMIT without stepping and reload rotors via INIT.

Structure
REQ-027 SHALL take letter width 5, ALPHA=26, the state enum and the default notch constants from shared package enigma_pkg.
REQ-028 SHALL instantiate sub-module enigma_pos_ctr (mod-26 position counter with load) three times for the pos_* shadows.

Verification
REQ-029 SHALL check: release rst -> 1 cycle of rotor_load=111, ld_val=0, key_ready=0; then key_ready=1, pos=0/0/0.
REQ-030 SHALL check: load 0/0/0, key 7 -> rotor_inc=001 for 1 cycle, pos_r=1, char_out=7 held until char_ready.
REQ-031 SHALL check: load r=21 m=0 l=0, key -> rotor_inc=011, pos_r=22, pos_m=1.
REQ-032 SHALL check double step: load l=0 m=3 r=20, three keys -> positions ADV, AEW, BFX, with the third rotor_inc=111.
REQ-033 SHALL check: simultaneous load_req and key_valid -> LOAD first, key accepted next IDLE; key_in=27 -> key_err=1, no rotor_inc.
REQ-034 SHALL check: rst asserted in EMIT -> char_valid=0 immediately, INIT load follows release.
